// File: rtl/intro_audio_pkg.sv
// Shared constants for the single-voice synth: note increment table, waveform
// codes, LFSR seed and the silence level used for the unsigned sample bus.
package intro_audio_pkg;

  localparam int NOTE_CNT = 12;

  // Phase increments for C3..B3 at the base octave; higher octaves shift left.
  localparam logic [8:0] NOTE_INC [NOTE_CNT] = '{
    9'd219, 9'd233, 9'd246, 9'd261, 9'd277, 9'd293,
    9'd310, 9'd329, 9'd348, 9'd369, 9'd391, 9'd414
  };

  typedef enum logic [1:0] {
    WAVE_SQR = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_AUX = 2'd3
  } wave_e;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [7:0]  SILENCE_LEVEL = 8'h80;

  // Notes 1..12 select a table entry; anything else yields zero (silence).
  function automatic logic [8:0] note_inc(input logic [3:0] note);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < NOTE_CNT; i++) begin
      if (note == 4'(i + 1)) r = NOTE_INC[i];
    end
    return r;
  endfunction

  function automatic logic note_gate(input logic [3:0] note);
    return (note >= 4'd1) && (note <= 4'd12);
  endfunction

endpackage

// File: rtl/synth_pwm_dac.sv
// First-order PWM DAC: free-running counter compared against the sample level,
// output registered so the pin never glitches.
module synth_pwm_dac
  import intro_audio_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] level,
  output logic              pwm
);

  logic [DATA_W-1:0] pwm_cnt;

  // A full counter wrap produces exactly `level` high clocks, so 0 stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DATA_W'(1);
      pwm     <= (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/intro_ii_audio_synth.sv
// Single-voice synth core: note-table phase accumulator, waveform shaper, 8-bit
// sample bus and PWM pin. Define SYNTH_NOISE_EN to make waveform 3 LFSR noise.
module intro_ii_audio_synth
  import intro_audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int               DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [7:0]       ui_q;
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      phase;
  logic [7:0]       sample;
  logic             strobe_q;
  logic             gate_q;
  logic             pwm_bit;

  logic [3:0]  note;
  logic [1:0]  octave;
  wave_e       wave_sel;
  logic        gate;
  logic        tick;
  logic [15:0] inc;
  logic [7:0]  wave_val;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

  function automatic logic [7:0] wave_shape(input wave_e w, input logic [7:0] p);
    logic [7:0] r;
    case (w)
      WAVE_SQR: r = p[7] ? 8'hFF : 8'h00;
      WAVE_SAW: r = p;
      WAVE_TRI: r = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default:  r = (p[7:6] == 2'b00) ? 8'hFF : 8'h00;
    endcase
    return r;
  endfunction

  // Decode from the registered pins only.
  assign note     = ui_q[3:0];
  assign octave   = ui_q[5:4];
  assign wave_sel = wave_e'(ui_q[7:6]);
  assign gate     = note_gate(note);
  assign inc      = {7'd0, note_inc(note)} << octave;
  assign tick     = (div_cnt == DIV_LAST);

`ifdef SYNTH_NOISE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (tick) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_comb begin
    wave_val = wave_shape(wave_sel, phase[15:8]);
    if (wave_sel == WAVE_AUX) wave_val = lfsr[7:0];
  end
`else
  always_comb begin
    wave_val = wave_shape(wave_sel, phase[15:8]);
  end
`endif

  // Sample uses the phase from before this tick's advance; note changes never
  // reset the phase, so retuning continues the waveform without a jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      ui_q     <= '0;
      div_cnt  <= '0;
      phase    <= '0;
      sample   <= SILENCE_LEVEL;
      strobe_q <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      ui_q     <= ui_in;
      div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
      strobe_q <= tick;
      gate_q   <= gate;
      if (tick) begin
        sample <= gate ? wave_val : SILENCE_LEVEL;
        if (gate) phase <= phase + inc;
      end
    end
  end

  synth_pwm_dac #(
    .DATA_W (8)
  ) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .level (sample),
    .pwm   (pwm_bit)
  );

  assign uo_out  = {5'b00000, gate_q, strobe_q, pwm_bit};
  assign uio_out = sample;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_intro_ii_audio_synth.sv
// Self-checking bench for intro_ii_audio_synth with a per-sample behavioural model.
module tb_intro_ii_audio_synth;

  localparam int SAMPLE_DIV = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad = 0;

  int m_phase;
  int m_lfsr;
  int note_tbl [12] = '{219, 233, 246, 261, 277, 293, 310, 329, 348, 369, 391, 414};

  always #5 clk = ~clk;

  intro_ii_audio_synth #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  function automatic int exp_wave(input int w, input int p, input int lf);
    if (w == 0) return (p >= 128) ? 255 : 0;
    if (w == 1) return p;
    if (w == 2) return (p < 128) ? 2 * p : 511 - 2 * p;
`ifdef SYNTH_NOISE_EN
    return lf % 256;
`else
    return (p < 64) ? 255 : 0;
`endif
  endfunction

  // One sample period of the reference: output value, then phase/LFSR advance.
  task automatic model_tick(input logic [7:0] ui, output int es, output logic eg);
    int note;
    int fb;
    note = int'(ui[3:0]);
    eg = (note >= 1 && note <= 12);
    es = eg ? exp_wave(int'(ui[7:6]), m_phase / 256, m_lfsr) : 128;
    if (eg) m_phase = (m_phase + (note_tbl[note - 1] << ui[5:4])) % 65536;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) % 65536;
  endtask

  task automatic do_reset(input logic [7:0] ui);
    @(negedge clk);
    rst = 1'b1;
    ui_in = ui;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_phase = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < SAMPLE_DIV + 8; i++) begin
      @(negedge clk);
      if (uo_out[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (uo_out[0]) hi++;
    end
  endtask

  task automatic test_reset;
    int first;
    @(negedge clk);
    rst = 1'b1;
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if (uio_out !== 8'h80) begin bad++; $display("FAIL reset_uio_out got=%h want=80", uio_out); end
    total++;
    if (uio_oe !== 8'hFF) begin bad++; $display("FAIL reset_uio_oe got=%h want=ff", uio_oe); end
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out got=%h want=00", uo_out); end
    rst = 1'b0;
    first = -1;
    for (int i = 1; i <= SAMPLE_DIV + 8; i++) begin
      @(negedge clk);
      if (uo_out[1]) begin
        first = i;
        break;
      end
    end
    total++;
    if (first !== SAMPLE_DIV) begin bad++; $display("FAIL first_strobe got=%0d want=%0d", first, SAMPLE_DIV); end
    total++;
    if (uio_out !== 8'h80 || uo_out[2] !== 1'b0) begin
      bad++; $display("FAIL silent_first_sample got=%h gate=%b want=80 gate=0", uio_out, uo_out[2]);
    end
  endtask

  task automatic test_square;
    bit ok;
    int es;
    logic eg;
    int first_ff;
    first_ff = -1;
    do_reset(8'h0A);
    for (int n = 1; n <= 92; n++) begin
      wait_strobe(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL square_timeout got=none want=strobe"); return; end
      model_tick(8'h0A, es, eg);
      if (uio_out !== 8'(es) || uo_out[2] !== eg) begin
        bad++; $display("FAIL square_sample n=%0d got=%h gate=%b want=%h gate=%b", n, uio_out, uo_out[2], 8'(es), eg);
      end
      if (first_ff < 0 && uio_out == 8'hFF) first_ff = n;
    end
    total++;
    if (first_ff !== 90) begin bad++; $display("FAIL square_half_period got=%0d want=90", first_ff); end
  endtask

  task automatic test_saw;
    bit ok;
    int es;
    logic eg;
    do_reset(8'h5A);
    for (int n = 1; n <= 5; n++) begin
      wait_strobe(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL saw_timeout got=none want=strobe"); return; end
      model_tick(8'h5A, es, eg);
      if (uio_out !== 8'(es)) begin bad++; $display("FAIL saw_sample n=%0d got=%h want=%h", n, uio_out, 8'(es)); end
    end
    total++;
    if (uio_out !== 8'h0B) begin bad++; $display("FAIL saw_fifth got=%h want=0b", uio_out); end
  endtask

  task automatic test_silence_resume;
    bit ok;
    int es;
    logic eg;
    logic [7:0] seq [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A};
    do_reset(8'h5A);
    for (int n = 0; n < 7; n++) begin
      wait_strobe(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL silence_timeout got=none want=strobe"); return; end
      model_tick(seq[n], es, eg);
      if (uio_out !== 8'(es) || uo_out[2] !== eg) begin
        bad++; $display("FAIL silence_sample n=%0d got=%h gate=%b want=%h gate=%b", n, uio_out, uo_out[2], 8'(es), eg);
      end
      if (n < 6) ui_in = seq[n + 1];
    end
    total++;
    if (uio_out !== 8'h08) begin bad++; $display("FAIL resume_phase got=%h want=08", uio_out); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int first;
    do_reset(8'h5A);
    repeat (2) wait_strobe(ok);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (uio_out !== 8'h80 || uo_out !== 8'h00) begin
      bad++; $display("FAIL mid_reset got=%h/%h want=80/00", uio_out, uo_out);
    end
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0;
    m_lfsr = 16'hACE1;
    first = -1;
    for (int i = 1; i <= SAMPLE_DIV + 8; i++) begin
      @(negedge clk);
      if (uo_out[1]) begin
        first = i;
        break;
      end
    end
    total++;
    if (first !== SAMPLE_DIV || uio_out !== 8'h00 || uo_out[2] !== 1'b1) begin
      bad++; $display("FAIL mid_reset_restart got=%0d/%h want=%0d/00", first, uio_out, SAMPLE_DIV);
    end
  endtask

  task automatic test_pwm;
    bit ok;
    int es;
    int hi;
    logic eg;
    do_reset(8'h01);
    wait_strobe(ok);
    model_tick(8'h01, es, eg);
    count_pwm(hi);
    total++;
    if (!ok || hi !== es || es !== 0) begin bad++; $display("FAIL pwm_zero got=%0d want=0", hi); end
    do_reset(8'hB4);
    for (int n = 1; n <= 5; n++) begin
      wait_strobe(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL pwm_timeout got=none want=strobe"); return; end
      model_tick(8'hB4, es, eg);
      if (uio_out !== 8'(es)) begin bad++; $display("FAIL tri_sample n=%0d got=%h want=%h", n, uio_out, 8'(es)); end
    end
    total++;
    if (uio_out !== 8'h40) begin bad++; $display("FAIL tri_level got=%h want=40", uio_out); end
    count_pwm(hi);
    total++;
    if (hi !== 64) begin bad++; $display("FAIL pwm_quarter got=%0d want=64", hi); end
  endtask

  task automatic test_aux;
    bit ok;
    int es;
    logic eg;
    logic [7:0] want_first;
`ifdef SYNTH_NOISE_EN
    want_first = 8'hE1;
`else
    want_first = 8'hFF;
`endif
    do_reset(8'hCA);
    for (int n = 1; n <= 6; n++) begin
      wait_strobe(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL aux_timeout got=none want=strobe"); return; end
      model_tick(8'hCA, es, eg);
      if (uio_out !== 8'(es)) begin bad++; $display("FAIL aux_sample n=%0d got=%h want=%h", n, uio_out, 8'(es)); end
      if (n == 1) begin
        total++;
        if (uio_out !== want_first) begin bad++; $display("FAIL aux_first got=%h want=%h", uio_out, want_first); end
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int es;
    logic eg;
    logic [7:0] cur;
    cur = 8'($urandom);
    do_reset(cur);
    for (int n = 0; n < 24; n++) begin
      wait_strobe(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL random_timeout got=none want=strobe"); return; end
      model_tick(cur, es, eg);
      if (uio_out !== 8'(es) || uo_out[2] !== eg || uo_out[7:3] !== 5'd0) begin
        bad++; $display("FAIL random_sample ui=%h got=%h uo=%h want=%h gate=%b", cur, uio_out, uo_out, 8'(es), eg);
      end
      cur = 8'($urandom);
      ui_in = cur;
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_saw;
    test_silence_resume;
    test_reset_mid;
    test_pwm;
    test_aux;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
